dp_ctrl_fsm: RTL and testbench
==============================

// Module: dp_ctrl_fsm
// PURPOSE
//  Control unit that sequences the 8-bit register-file/ALU datapath directly downstream of it.
//  On start it runs a fixed program computing sum(1..LIMIT) mod 256 in the datapath register file.
//  It then latches the result into the datapath OutPort register and pulses done.
//  The datapath's lte (RData1 < RData2, unsigned) is the only status input.
// PARAMETERS
//  LIMIT   10   loop bound N, 0..255; result = N*(N+1)/2 mod 256
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  asynchronous, active-high
//  start        in   1  run request, sampled in IDLE only
//  lte          in   1  datapath compare result (RData1 < RData2)
//  RFSrcMuxSel  out  1  0: write ALU result, 1: write constant 8'd1
//  RAddr1       out  3  regfile read port 1 address
//  RAddr2       out  3  regfile read port 2 address
//  WAddr        out  3  regfile write address
//  we           out  1  regfile write enable
//  ALUop        out  2  0 ADD, 1 SUB, 2 AND, 3 OR (this program uses ADD only)
//  OutPortEn    out  1  load datapath OutPort from RData1
//  busy         out  1  high in every state except IDLE
//  done         out  1  one-cycle pulse, OutPort valid
// BEHAVIOUR
//  Moore FSM; all datapath controls decode from state only. Internal 8-bit build counter cnt.
//  Register map: R0 reads 0; R1 = one, R2 = i, R3 = sum, R4 = limit.
//  Idle/default controls: addresses 0, we 0, RFSrcMuxSel 0, ALUop 0, OutPortEn 0.
//  Reset: state IDLE, cnt 0, all outputs at idle values, busy 0, done 0.
//  Regfile contents are not reset. OutPort reset is owned by the datapath.
//  States (action -> next):
//   IDLE   : no writes; start=1 -> ONE, else stay
//   ONE    : RFSrcMuxSel 1, WAddr 1, we            -> CLR_I
//   CLR_I  : R2 <= R0+R0 (RAddr1 0, RAddr2 0, ADD, WAddr 2, we) -> CLR_S
//   CLR_S  : same with WAddr 3                     -> CLR_L
//   CLR_L  : same with WAddr 4, cnt <= 0           -> BUILD if LIMIT!=0, else CMP
//   BUILD  : R4 <= R4+R1 (RAddr1 4, RAddr2 1, WAddr 4, we), cnt++
//            -> CMP when cnt==LIMIT-1, else stay (exactly LIMIT cycles)
//   CMP    : RAddr1 2, RAddr2 4, we 0; lte=1 -> INC, lte=0 -> OUT
//   INC    : R2 <= R2+R1 (RAddr1 2, RAddr2 1, WAddr 2, we) -> ACC
//   ACC    : R3 <= R3+R2 (RAddr1 3, RAddr2 2, WAddr 3, we) -> CMP
//   OUT    : RAddr1 3, OutPortEn 1                 -> DONE
//   DONE   : done 1, no writes                     -> IDLE
//  Latency: the DONE state is entered 4*LIMIT+6 rising edges after the edge that samples start.
//  OutPort is loaded on the same edge that enters DONE, so it is valid while done=1.
//  start while busy is ignored; start held high re-triggers on the first IDLE cycle after DONE.
//  All arithmetic is 8-bit wrap. The i<limit compare is unsigned, so LIMIT=255 terminates.
//  reset mid-run: immediate return to IDLE with idle controls; the next start reruns the full program.
//  we is never asserted with WAddr 0. Exactly one write per write-state cycle.
// TESTING
//  LIMIT=10, pulse start -> done after 46 edges, OutPort=8'h37, busy high throughout.
//  LIMIT=0 -> BUILD skipped, done after 6 edges, OutPort=8'h00.
//  LIMIT=23 -> OutPort=8'h14 (wrap of 276). LIMIT=255 -> OutPort=8'h80, done after 1026 edges.
//  Pulse start again mid-run (LIMIT=10) -> ignored; single done, OutPort=8'h37.
//  Assert reset during the INC/ACC loop -> outputs idle immediately. Restart -> OutPort=8'h37.
//  Hold start high for 2 runs -> back-to-back runs with IDLE for one cycle between DONE and ONE.
//  Bind checker: we=1 implies WAddr!=0. done is exactly 1 cycle.

Source files
------------

// File: rtl/dp_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ctrl_fsm
//  Description : Control unit for the 8-bit register-file/ALU datapath.
//                On start it runs a fixed program that computes
//                sum(1..LIMIT) mod 256 in the register file. It then loads
//                the datapath OutPort from R3 and pulses done for one cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  clock, rising edge
//    reset        in   1  asynchronous, active-high
//    start        in   1  run request, sampled in IDLE only
//    lte          in   1  datapath compare result (RData1 < RData2, unsigned)
//    RFSrcMuxSel  out  1  0: write ALU result, 1: write constant 8'd1
//    RAddr1       out  3  regfile read port 1 address
//    RAddr2       out  3  regfile read port 2 address
//    WAddr        out  3  regfile write address
//    we           out  1  regfile write enable
//    ALUop        out  2  0 ADD, 1 SUB, 2 AND, 3 OR
//    OutPortEn    out  1  load datapath OutPort from RData1
//    busy         out  1  high in every state except IDLE
//    done         out  1  one-cycle pulse, OutPort valid
//  Register map: R0 reads 0, R1 = one, R2 = i, R3 = sum, R4 = limit
// ============================================================================
module dp_ctrl_fsm #(
  parameter int LIMIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       lte,
  output logic       RFSrcMuxSel,
  output logic [2:0] RAddr1,
  output logic [2:0] RAddr2,
  output logic [2:0] WAddr,
  output logic       we,
  output logic [1:0] ALUop,
  output logic       OutPortEn,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ONE   = 4'd1,
    S_CLR_I = 4'd2,
    S_CLR_S = 4'd3,
    S_CLR_L = 4'd4,
    S_BUILD = 4'd5,
    S_CMP   = 4'd6,
    S_INC   = 4'd7,
    S_ACC   = 4'd8,
    S_OUT   = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  // Last counter value of the build loop; wraps to 255 for LIMIT=0, but the
  // build loop is skipped entirely in that case.
  localparam logic [7:0] C_LIMIT_M1 = 8'((LIMIT + 255) % 256);
  localparam logic       C_HAS_BUILD = (LIMIT != 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       rfsrc_d, we_d, oen_d, busy_d, done_d;
  logic [2:0] raddr1_d, raddr2_d, waddr_d;
  logic [1:0] aluop_d;

  // Next state and build counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ONE;
      S_ONE:   state_d = S_CLR_I;
      S_CLR_I: state_d = S_CLR_S;
      S_CLR_S: state_d = S_CLR_L;
      S_CLR_L: begin
        cnt_d   = 8'd0;
        state_d = C_HAS_BUILD ? S_BUILD : S_CMP;
      end
      S_BUILD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == C_LIMIT_M1) state_d = S_CMP;
      end
      S_CMP:   state_d = lte ? S_INC : S_OUT;
      S_INC:   state_d = S_ACC;
      S_ACC:   state_d = S_CMP;
      S_OUT:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controls are decoded from the next state so that the registered outputs
  // line up with the state register (Moore outputs without a decode delay).
  always_comb begin
    rfsrc_d  = 1'b0;
    raddr1_d = 3'd0;
    raddr2_d = 3'd0;
    waddr_d  = 3'd0;
    we_d     = 1'b0;
    aluop_d  = 2'd0;
    oen_d    = 1'b0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    unique case (state_d)
      S_ONE: begin
        rfsrc_d = 1'b1;
        waddr_d = 3'd1;
        we_d    = 1'b1;
      end
      // R0+R0 clears the destination register
      S_CLR_I: begin waddr_d = 3'd2; we_d = 1'b1; end
      S_CLR_S: begin waddr_d = 3'd3; we_d = 1'b1; end
      S_CLR_L: begin waddr_d = 3'd4; we_d = 1'b1; end
      S_BUILD: begin
        raddr1_d = 3'd4;
        raddr2_d = 3'd1;
        waddr_d  = 3'd4;
        we_d     = 1'b1;
      end
      S_CMP: begin
        raddr1_d = 3'd2;
        raddr2_d = 3'd4;
      end
      S_INC: begin
        raddr1_d = 3'd2;
        raddr2_d = 3'd1;
        waddr_d  = 3'd2;
        we_d     = 1'b1;
      end
      S_ACC: begin
        raddr1_d = 3'd3;
        raddr2_d = 3'd2;
        waddr_d  = 3'd3;
        we_d     = 1'b1;
      end
      S_OUT: begin
        raddr1_d = 3'd3;
        oen_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      RFSrcMuxSel <= 1'b0;
      RAddr1      <= 3'd0;
      RAddr2      <= 3'd0;
      WAddr       <= 3'd0;
      we          <= 1'b0;
      ALUop       <= 2'd0;
      OutPortEn   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      RFSrcMuxSel <= rfsrc_d;
      RAddr1      <= raddr1_d;
      RAddr2      <= raddr2_d;
      WAddr       <= waddr_d;
      we          <= we_d;
      ALUop       <= aluop_d;
      OutPortEn   <= oen_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_ctrl_fsm
//  Description : Bench for dp_ctrl_fsm. Four controllers (LIMIT 10, 0, 23,
//                255) share clk/reset/start, each driving its own datapath
//                model. A per-instance timeline model predicts busy/done from
//                the run length 4*N+6, and the OutPort value N*(N+1)/2 mod 256.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_ctrl_fsm;

  localparam int C_NINST = 4;
  localparam logic [31:0] C_LIMS = {8'd255, 8'd23, 8'd0, 8'd10};

  logic clk = 1'b0;
  logic reset;
  logic start;

  int n_checks = 0;
  int n_errors = 0;

  logic [C_NINST-1:0] busy_w, done_w, we_w, oen_w;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < C_NINST; g++) begin : g_dut
    localparam int LIM = int'(C_LIMS[g*8 +: 8]);
    localparam int RUN_LEN = 4 * LIM + 6;
    localparam logic [7:0] EXP_OUT = 8'((LIM * (LIM + 1) / 2) % 256);

    logic       sel, we, oen, busy, done, lte;
    logic [2:0] ra1, ra2, wa;
    logic [1:0] aluop;
    logic [7:0] rf [8];
    logic [7:0] rd1, rd2, alu, outp;
    bit         m_run = 1'b0;
    int         m_t = 0;
    int         done_cnt = 0;

    dp_ctrl_fsm #(.LIMIT(LIM)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .lte        (lte),
      .RFSrcMuxSel(sel),
      .RAddr1     (ra1),
      .RAddr2     (ra2),
      .WAddr      (wa),
      .we         (we),
      .ALUop      (aluop),
      .OutPortEn  (oen),
      .busy       (busy),
      .done       (done)
    );

    assign busy_w[g] = busy;
    assign done_w[g] = done;
    assign we_w[g]   = we;
    assign oen_w[g]  = oen;

    // Datapath: R0 reads as zero, 8-bit wrapping ALU, OutPort loads RData1
    assign rd1 = (ra1 == 3'd0) ? 8'd0 : rf[ra1];
    assign rd2 = (ra2 == 3'd0) ? 8'd0 : rf[ra2];
    assign lte = (rd1 < rd2);
    always_comb begin
      case (aluop)
        2'd0:    alu = rd1 + rd2;
        2'd1:    alu = rd1 - rd2;
        2'd2:    alu = rd1 & rd2;
        default: alu = rd1 | rd2;
      endcase
    end
    always @(posedge clk) begin
      if (we) rf[wa] <= sel ? 8'd1 : alu;
    end
    always @(posedge clk or posedge reset) begin
      if (reset)    outp <= 8'd0;
      else if (oen) outp <= rd1;
    end

    // Timeline model: a run lasts RUN_LEN edges after the start edge, then
    // one edge back to idle where start is looked at again.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        m_run = 1'b0;
        m_t   = 0;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1'b1;
          m_t   = 0;
        end
      end else if (m_t == RUN_LEN) begin
        m_run = 1'b0;
      end else begin
        m_t++;
      end
    end

    always begin
      @(posedge clk);
      #1;
      check($sformatf("busy[%0d]", g), {31'd0, busy}, {31'd0, m_run});
      check($sformatf("done[%0d]", g), {31'd0, done}, {31'd0, (m_run && m_t == RUN_LEN)});
      check($sformatf("aluop[%0d]", g), {30'd0, aluop}, 32'd0);
      if (we) check($sformatf("we_waddr0[%0d]", g), {31'd0, (wa != 3'd0)}, 32'd1);
      if (!m_run)
        check($sformatf("idle_ctl[%0d]", g), {19'd0, sel, ra1, ra2, wa, we, aluop, oen}, 32'd0);
      if (done) begin
        check($sformatf("outport[%0d]", g), {24'd0, outp}, {24'd0, EXP_OUT});
        done_cnt++;
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single run with a stray start pulse mid-run
    c0 = g_dut[0].done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1100) @(negedge clk);
    check("single_done", g_dut[0].done_cnt - c0, 1);

    // Start held for two back-to-back runs of the LIMIT=10 controller
    c0 = g_dut[0].done_cnt;
    start = 1'b1;
    repeat (96) @(negedge clk);
    start = 1'b0;
    repeat (1100) @(negedge clk);
    check("b2b_runs", g_dut[0].done_cnt - c0, 2);

    // Reset in the middle of the INC/ACC loop, then a full rerun
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", {28'd0, busy_w}, 32'd0);
    check("rst_done", {28'd0, done_w}, 32'd0);
    check("rst_we",   {28'd0, we_w},   32'd0);
    check("rst_oen",  {28'd0, oen_w},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    c0 = g_dut[0].done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1100) @(negedge clk);
    check("rerun_done", g_dut[0].done_cnt - c0, 1);

    // Random start pulses with occasional resets
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (1100) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
